// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Instruction-cycle state machine feeding the control unit. Walks the fetch
// states, decodes the IR opcode in fetch5, steps through each instruction's
// execute states, and tracks halt / illegal-opcode / timeout status plus a
// retired-instruction counter.
//
// Optional feature: define SEQ_TIMEOUT_EN to bound memory wait states to
// TIMEOUT_CYCLES consecutive stalled cycles. Without it, wait states hold
// indefinitely and `timeout` stays 0.
// -----------------------------------------------------------------------------
module instr_sequencer #(
   parameter int                  OPCODE_W    = 8,
   parameter logic [OPCODE_W-1:0] HALT_OPCODE = 8'hFF
`ifdef SEQ_TIMEOUT_EN
   ,
   parameter int                  TIMEOUT_CYCLES = 255
`endif
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   input  logic [OPCODE_W-1:0] ir_opcode,
   input  logic                mem_ready,
   output logic [5:0]          state,
   output logic                busy,
   output logic                halted,
   output logic                illegal_op,
   output logic                timeout,
   output logic [15:0]         instr_count
);

   // Encodings are shared with the control unit and must not change.
   typedef enum logic [5:0] {
      S_IDLE   = 6'd0,
      S_FETCH1 = 6'd1,
      S_FETCH2 = 6'd2,
      S_FETCH3 = 6'd3,
      S_FETCH4 = 6'd4,
      S_FETCH5 = 6'd5,
      S_CLAC   = 6'd6,
      S_LDAC1  = 6'd7,
      S_LDAC2  = 6'd8,
      S_LDAC3  = 6'd9,
      S_LDAC4  = 6'd10,
      S_STAC1  = 6'd11,
      S_STAC2  = 6'd12,
      S_STAC3  = 6'd13,
      S_STAC4  = 6'd14,
      S_MVACR  = 6'd15,
      S_MVRAC  = 6'd16,
      S_ADD    = 6'd17,
      S_MUL    = 6'd18
   } state_e;

   state_e        state_q, state_d;
   logic          halted_q, halted_d;
   logic          illegal_q, illegal_d;
   logic          timeout_q, timeout_d;
   logic [15:0]   count_q, count_d;

   // Per-cycle events produced by the next-state logic.
   logic          flag_clr;
   logic          halt_set;
   logic          illegal_set;
   logic          timeout_set;
   logic          retire;
   logic          stall_limit;

`ifdef SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic             in_wait;
   logic [CNT_W-1:0] wait_q, wait_d;

   // Stall counter: counts consecutive mem_ready-low cycles in a wait state,
   // and is zero whenever the machine is outside a wait state.
   always_comb begin
      in_wait     = (state_q == S_FETCH3) || (state_q == S_LDAC3) || (state_q == S_STAC3);
      wait_d      = (in_wait && !mem_ready) ? wait_q + 1'b1 : '0;
      stall_limit = (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));
   end

   // Stall counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) wait_q <= '0;
      else          wait_q <= wait_d;
   end
`else
   assign stall_limit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic: sequencing, opcode decode and status events.
   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      state_d     = state_q;
      flag_clr    = 1'b0;
      halt_set    = 1'b0;
      illegal_set = 1'b0;
      timeout_set = 1'b0;
      retire      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_FETCH1;
               flag_clr = 1'b1;
            end
         end
         S_FETCH1: state_d = S_FETCH2;
         S_FETCH2: state_d = S_FETCH3;
         S_FETCH3: begin
            if (mem_ready) state_d = S_FETCH4;
            else if (stall_limit) begin
               state_d     = S_IDLE;
               timeout_set = 1'b1;
            end
         end
         S_FETCH4: state_d = S_FETCH5;
         S_FETCH5: begin
            if      (ir_opcode == OPCODE_W'(1)) state_d = S_CLAC;
            else if (ir_opcode == OPCODE_W'(2)) state_d = S_LDAC1;
            else if (ir_opcode == OPCODE_W'(3)) state_d = S_STAC1;
            else if (ir_opcode == OPCODE_W'(4)) state_d = S_MVACR;
            else if (ir_opcode == OPCODE_W'(5)) state_d = S_MVRAC;
            else if (ir_opcode == OPCODE_W'(6)) state_d = S_ADD;
            else if (ir_opcode == OPCODE_W'(7)) state_d = S_MUL;
            else if (ir_opcode == HALT_OPCODE) begin
               state_d  = S_IDLE;
               halt_set = 1'b1;
               retire   = 1'b1;
            end else begin
               state_d     = S_FETCH1;
               illegal_set = 1'b1;
            end
         end
         S_CLAC, S_MVACR, S_MVRAC, S_ADD, S_MUL: begin
            state_d = S_FETCH1;
            retire  = 1'b1;
         end
         S_LDAC1: state_d = S_LDAC2;
         S_LDAC2: state_d = S_LDAC3;
         S_LDAC3: begin
            if (mem_ready) state_d = S_LDAC4;
            else if (stall_limit) begin
               state_d     = S_IDLE;
               timeout_set = 1'b1;
            end
         end
         S_LDAC4: begin
            state_d = S_FETCH1;
            retire  = 1'b1;
         end
         S_STAC1: state_d = S_STAC2;
         S_STAC2: state_d = S_STAC3;
         S_STAC3: begin
            if (mem_ready) state_d = S_STAC4;
            else if (stall_limit) begin
               state_d     = S_IDLE;
               timeout_set = 1'b1;
            end
         end
         S_STAC4: begin
            state_d = S_FETCH1;
            retire  = 1'b1;
         end
         default: begin
            // Corrupted encoding: recover to idle and flag it.
            state_d     = S_IDLE;
            illegal_set = 1'b1;
         end
      endcase
   end

   // Sticky status flags and retire counter next values.
   always_comb begin
      if (flag_clr) begin
         halted_d  = 1'b0;
         illegal_d = 1'b0;
         timeout_d = 1'b0;
      end else begin
         halted_d  = halted_q  | halt_set;
         illegal_d = illegal_q | illegal_set;
         timeout_d = timeout_q | timeout_set;
      end
      count_d = retire ? count_q + 16'd1 : count_q;
   end

   // Status and counter registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
         count_q   <= 16'd0;
      end else begin
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
      end
   end

   // Output decode: everything comes straight from registers.
   always_comb begin
      state       = state_q;
      busy        = (state_q != S_IDLE);
      halted      = halted_q;
      illegal_op  = illegal_q;
      timeout     = timeout_q;
      instr_count = count_q;
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Directed scenarios followed by randomized stimulus, all checked against a
// queue-based model: the model holds the list of state numbers still to be
// visited in the current fetch or execute sequence.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [7:0]  ir_opcode;
   logic        mem_ready;
   logic [5:0]  state;
   logic        busy;
   logic        halted;
   logic        illegal_op;
   logic        timeout;
   logic [15:0] instr_count;

   always #5 clock = ~clock;

`ifdef SEQ_TIMEOUT_EN
   localparam int TO = 4;
   instr_sequencer #(.OPCODE_W(8), .HALT_OPCODE(8'hFF), .TIMEOUT_CYCLES(TO)) dut (
`else
   instr_sequencer #(.OPCODE_W(8), .HALT_OPCODE(8'hFF)) dut (
`endif
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .ir_opcode   (ir_opcode),
      .mem_ready   (mem_ready),
      .state       (state),
      .busy        (busy),
      .halted      (halted),
      .illegal_op  (illegal_op),
      .timeout     (timeout),
      .instr_count (instr_count)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int q[$];          // state numbers still to visit; q[0] is the current one
   bit m_halted, m_illegal, m_timeout;
   int m_count;
   int m_stall;

   function automatic int m_state();
      return (q.size() == 0) ? 0 : q[0];
   endfunction

   task automatic push_seq(input int first, input int last);
      for (int i = first; i <= last; i++) q.push_back(i);
   endtask

   task automatic model_reset();
      q.delete();
      m_halted  = 0;
      m_illegal = 0;
      m_timeout = 0;
      m_count   = 0;
      m_stall   = 0;
   endtask

   // Advance the model by one clock edge given the inputs during that cycle.
   task automatic model_step(input bit st, input int op, input bit rdy);
      int s;
      if (q.size() == 0) begin
         if (st) begin
            push_seq(1, 5);
            m_halted  = 0;
            m_illegal = 0;
            m_timeout = 0;
            m_stall   = 0;
         end
         return;
      end
      s = q[0];
      if ((s == 3 || s == 9 || s == 13) && !rdy) begin
`ifdef SEQ_TIMEOUT_EN
         m_stall++;
         if (m_stall == TO) begin
            q.delete();
            m_timeout = 1;
            m_stall   = 0;
         end
`endif
         return;
      end
      m_stall = 0;
      void'(q.pop_front());
      if (q.size() != 0) return;
      if (s == 5) begin
         case (op)
            1:       q.push_back(6);
            2:       push_seq(7, 10);
            3:       push_seq(11, 14);
            4:       q.push_back(15);
            5:       q.push_back(16);
            6:       q.push_back(17);
            7:       q.push_back(18);
            8'hFF: begin
               m_halted = 1;
               m_count  = (m_count + 1) % 65536;
            end
            default: begin
               m_illegal = 1;
               push_seq(1, 5);
            end
         endcase
      end else begin
         m_count = (m_count + 1) % 65536;
         push_seq(1, 5);
      end
   endtask

   task automatic check_all();
      check("state",       32'(state),       m_state());
      check("busy",        32'(busy),        32'(m_state() != 0));
      check("halted",      32'(halted),      32'(m_halted));
      check("illegal_op",  32'(illegal_op),  32'(m_illegal));
      check("timeout",     32'(timeout),     32'(m_timeout));
      check("instr_count", 32'(instr_count), m_count);
   endtask

   // Apply inputs for one cycle, advance the model, sample #1 after the edge.
   task automatic step(input bit st, input int op, input bit rdy);
      start     = st;
      ir_opcode = 8'(op);
      mem_ready = rdy;
      model_step(st, op, rdy);
      @(posedge clock);
      #1;
      check_all();
   endtask

   // Asynchronous reset pulse in the middle of a cycle.
   task automatic async_reset();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      int exp1[7];
      bit st, rdy;
      int op, k;
      exp1 = '{1, 2, 3, 4, 5, 17, 1};

      reset_n   = 1'b0;
      start     = 1'b0;
      ir_opcode = 8'd0;
      mem_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_all();
      @(negedge clock);
      reset_n = 1'b1;

      // ADD: fixed state sequence from idle
      for (int i = 0; i < 7; i++) begin
         step(i == 0, 6, 1'b1);
         check("add_seq", 32'(state), exp1[i]);
      end
      check("add_count", 32'(instr_count), 1);

      // LDAC with three stalled cycles in ldac3
      repeat (4) step(0, 2, 1'b1);
      repeat (3) step(0, 2, 1'b1);
      repeat (3) step(0, 2, 1'b0);
      step(0, 2, 1'b1);
      check("ldac_in_ldac4", 32'(state), 10);
      step(0, 2, 1'b1);
      check("ldac_count", 32'(instr_count), 2);

      // HALT then restart
      repeat (4) step(0, 8'hFF, 1'b1);
      step(0, 8'hFF, 1'b1);
      check("halt_state", 32'(state), 0);
      check("halt_flag", 32'(halted), 1);
      step(1, 0, 1'b1);
      check("restart_halted", 32'(halted), 0);

      // Illegal opcode
      repeat (4) step(0, 8'h2A, 1'b1);
      step(0, 8'h2A, 1'b1);
      check("illegal_state", 32'(state), 1);
      check("illegal_count", 32'(instr_count), 3);

      // STAC interrupted by asynchronous reset in stac2
      repeat (4) step(0, 3, 1'b1);
      step(0, 3, 1'b1);
      step(0, 3, 1'b1);
      check("stac2_reached", 32'(state), 12);
      async_reset();

      // Long stall in fetch3 (times out only when the feature is built in)
      step(1, 0, 1'b1);
      step(0, 0, 1'b1);
      step(0, 0, 1'b1);
      repeat (6) step(0, 0, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         st  = ($urandom_range(0, 1) == 1);
         rdy = ($urandom_range(0, 9) < 7);
         k   = int'($urandom_range(0, 19));
         if (k < 14)      op = 1 + (k % 7);
         else if (k < 16) op = 8'hFF;
         else             op = int'($urandom_range(0, 255));
         step(st, op, rdy);
         if ($urandom_range(0, 199) == 0) async_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
